// File: rtl/regfile_nport_if.sv
// Bus bundle for regfile_nport: one write port and NRD packed read ports.
interface regfile_nport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic                  we;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;
    logic [NRD-1:0]        rd_en;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rd_valid;

    modport master (
        output we, waddr, wdata, rd_en, raddr,
        input  rdata, rd_valid
    );

    modport slave (
        input  we, waddr, wdata, rd_en, raddr,
        output rdata, rd_valid
    );
endinterface

// File: rtl/regfile_nport.sv
// N-read / 1-write register file, register 0 hardwired to zero, 1-cycle registered reads.
// Define REGFILE_BYPASS_EN for write-first collisions; default build is read-first.
module regfile_nport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input logic            clk,
    input logic            rst,
    regfile_nport_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic                  wr_ok;
    logic [ADDR_W-1:0]     rd_addr [NRD];
    logic [DATA_W-1:0]     rd_word [NRD];
    logic [NRD*DATA_W-1:0] rdata_q;
    logic [NRD-1:0]        rd_valid_q;

    assign wr_ok = bus.we && (bus.waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    // Address 0 is gated here rather than relying on mem[0] staying cleared.
    always_comb begin
        for (int unsigned p = 0; p < NRD; p++) begin
            rd_addr[p] = bus.raddr[p*ADDR_W +: ADDR_W];
            rd_word[p] = (rd_addr[p] == '0) ? '0 : mem[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (rd_addr[p] == bus.waddr)) begin
                rd_word[p] = bus.wdata;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q    <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            for (int unsigned p = 0; p < NRD; p++) begin
                if (bus.rd_en[p]) begin
                    rdata_q[p*DATA_W +: DATA_W] <= rd_word[p];
                end
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_regfile_nport.sv
// Scoreboard bench for regfile_nport (NRD=2, ADDR_W=5, DATA_W=32); honours REGFILE_BYPASS_EN.
module tb_regfile_nport;
    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst    = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [32];
    logic [31:0] last  [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

`ifdef REGFILE_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    regfile_nport_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus ();

    regfile_nport #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = clk_en ? ~clk : clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a, input logic w,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (BYPASS && w && (wa != 5'd0) && (wa == a)) return wd;
        return model[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        last[0] = 32'd0;
        last[1] = 32'd0;
        q0.delete();
        q1.delete();
    endtask

    // Called just after a falling edge; drives one cycle and checks its results.
    task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
        logic [31:0] e;
        bus.we    = w;
        bus.waddr = wa;
        bus.wdata = wd;
        bus.rd_en = en;
        bus.raddr = {a1, a0};
        if (en[0]) q0.push_back(exp_read(a0, w, wa, wd));
        if (en[1]) q1.push_back(exp_read(a1, w, wa, wd));
        @(posedge clk);
        if (w && (wa != 5'd0)) model[wa] = wd;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("valid%0d", p), 64'(bus.rd_valid[p]), 64'(en[p]));
            if (en[p]) begin
                if ((p == 0 ? q0.size() : q1.size()) == 0) begin
                    chk($sformatf("sb_underflow%0d", p), 64'd1, 64'd0);
                end else begin
                    e = (p == 0) ? q0.pop_front() : q1.pop_front();
                    last[p] = e;
                end
            end
            chk($sformatf("rdata%0d", p), 64'(bus.rdata[p*32 +: 32]), 64'(last[p]));
        end
    endtask

    initial begin
        logic        w;
        logic [4:0]  wa, a0, a1;
        logic [31:0] wd;
        logic [1:0]  en;

        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.rd_en = '0; bus.raddr = '0;
        model_reset();

        // reset with the clock stopped
        #2 rst = 1'b1;
        #1;
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_valid", 64'(bus.rd_valid), 64'd0);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < 32; a++) cycle(1'b0, 5'd0, 32'd0, 2'b11, 5'(a), 5'(31 - a));

        cycle(1'b1, 5'd7, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 2'b01, 5'd7, 5'd0);
        chk("wr_rd7", 64'(bus.rdata[31:0]), 64'hDEADBEEF);

        cycle(1'b1, 5'd0, 32'h12345678, 2'b00, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 2'b11, 5'd0, 5'd0);
        chk("reg0_p0", 64'(bus.rdata[31:0]), 64'd0);
        chk("reg0_p1", 64'(bus.rdata[63:32]), 64'd0);

        cycle(1'b1, 5'd5, 32'h11, 2'b00, 5'd0, 5'd0);
        cycle(1'b1, 5'd5, 32'h22, 2'b01, 5'd5, 5'd0);
        chk("collide", 64'(bus.rdata[31:0]), BYPASS ? 64'h22 : 64'h11);
        cycle(1'b0, 5'd0, 32'd0, 2'b01, 5'd5, 5'd0);
        chk("after_collide", 64'(bus.rdata[31:0]), 64'h22);

        for (int k = 1; k <= 3; k++) cycle(1'b1, 5'(k), 32'hA0 + 32'(k), 2'b00, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 2'b11, 5'd1, 5'd3);
        chk("stream_valid", 64'(bus.rd_valid), 64'd3);
        cycle(1'b0, 5'd0, 32'd0, 2'b11, 5'd2, 5'd2);
        chk("stream_same", 64'(bus.rdata[63:32]), 64'(bus.rdata[31:0]));
        cycle(1'b0, 5'd0, 32'd0, 2'b11, 5'd3, 5'd1);
        cycle(1'b0, 5'd0, 32'd0, 2'b01, 5'd1, 5'd3);
        chk("drop_valid1", 64'(bus.rd_valid[1]), 64'd0);
        chk("hold1", 64'(bus.rdata[63:32]), 64'hA1);

        for (int n = 0; n < 60; n++) begin
            w  = 1'($urandom_range(0, 1));
            wa = 5'($urandom);
            wd = $urandom;
            en = 2'($urandom);
            a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            cycle(w, wa, wd, en, a0, a1);
        end

        // reset mid-stream with a write pending on the same edge
        cycle(1'b1, 5'd9, 32'h5A5A, 2'b00, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 2'b01, 5'd9, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 2'b01, 5'd9, 5'd0);
        bus.rd_en = 2'b01; bus.raddr = {5'd0, 5'd9};
        bus.we = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'hABCD;
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(bus.rd_valid), 64'd0);
        chk("midrst_rdata", 64'(bus.rdata), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_hold", 64'(bus.rdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.we = 1'b0;
        model_reset();
        cycle(1'b0, 5'd0, 32'd0, 2'b11, 5'd10, 5'd9);
        chk("lost_write", 64'(bus.rdata[31:0]), 64'd0);
        chk("cleared9", 64'(bus.rdata[63:32]), 64'd0);

        cycle(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        chk("sb_drain0", 64'(q0.size()), 64'd0);
        chk("sb_drain1", 64'(q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_nport.md
REGFILE_NPORT -- requirements
Module: regfile_nport

Interface
REQ-001 Parameter DATA_W, default 32, width of each register and data path in bits.
REQ-002 Parameter ADDR_W, default 5, address width; register count DEPTH = 2^ADDR_W.
REQ-003 Parameter NRD, default 2, number of independent read ports.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 we  input  1  write enable.
REQ-007 waddr  input  ADDR_W  write address.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 rd_en  input  NRD  per-port read request; bit p belongs to port p.
REQ-010 raddr  input  NRD*ADDR_W  packed read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-011 rdata  output  NRD*DATA_W  packed registered read data; port p occupies bits [p*DATA_W +: DATA_W].
REQ-012 rd_valid  output  NRD  per-port flag: rdata for port p is valid this cycle.

Function
REQ-013 Storage SHALL be DEPTH registers of DATA_W bits; register 0 SHALL always read as 0, and writes to address 0 SHALL be discarded.
REQ-014 Write: on a rising edge with we=1 and waddr!=0, register[waddr] SHALL take wdata; it is visible to reads launched from the next edge onward.
REQ-015 Read: on a rising edge with rd_en[p]=1, rdata port p SHALL load the selected register value, and rd_valid[p] SHALL be 1 in the following cycle; read latency is exactly 1 cycle.
REQ-016 With rd_en[p]=0 at an edge, rd_valid[p] SHALL go to 0, and rdata port p SHALL hold its previous value.
REQ-017 Ports SHALL operate independently; any number of ports MAY read the same address in the same cycle and SHALL all return the same value.
REQ-018 Simultaneous write and read of the same nonzero address in one cycle SHALL follow REQ-027/REQ-028.
REQ-019 Back-to-back reads on every cycle SHALL be supported with no bubble; rd_valid[p] stays 1 while rd_en[p] stays 1.
REQ-020 Address decode SHALL cover all DEPTH values; no out-of-range case exists, and no X SHALL propagate to rdata after reset.
REQ-021 NRD=1 and ADDR_W=1 SHALL be legal and behave per the rules above.

Reset
REQ-022 While rst=1, all registers SHALL read 0, rdata SHALL be 0 and rd_valid SHALL be 0, without waiting for a clock edge.
REQ-023 A reset asserted mid-operation SHALL abort any read in flight: rd_valid goes to 0 immediately, and any write on that edge is lost.
REQ-024 On the first rising edge after rst deasserts, writes and reads SHALL be accepted normally.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN selects the read/write collision behaviour.
REQ-026 The bypass applies only to a collision: we=1, waddr!=0 and raddr[p]==waddr at the same edge.
REQ-027 With REGFILE_BYPASS_EN defined: the read returns the new value (write-first); rdata port p SHALL equal wdata.
REQ-028 Without REGFILE_BYPASS_EN: the read returns the value stored before the edge (read-first); wdata is visible from the next read.

Verification
REQ-029 Reset: assert rst with the clock stopped -> rdata=0 and rd_valid=0 immediately; after release, read addresses 0..31 -> all return 0.
REQ-030 Write then read: write 0xDEADBEEF to reg 7; next cycle port0 reads 7 -> one cycle later rdata0=0xDEADBEEF and rd_valid[0]=1.
REQ-031 Register zero: write 0x12345678 to reg 0, then read reg 0 on both ports -> rdata0=rdata1=0.
REQ-032 Collision: reg 5 holds 0x11; write 0x22 to reg 5 and read reg 5 in the same cycle -> 0x22 with REGFILE_BYPASS_EN, 0x11 without it; the following read returns 0x22 in both builds.
REQ-033 Multi-port streaming: NRD=2; port0 reads 1,2,3 and port1 reads 3,2,1 on consecutive cycles -> matching data each cycle, rd_valid held at 11; drop rd_en[1] -> rd_valid[1]=0 and rdata1 holds its last value.
REQ-034 Reset mid-stream: assert rst while port0 reads every cycle -> rd_valid[0]=0 and rdata0=0 at once; a write issued in the same cycle is absent after reset.
